// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types for the multi-mode SPI controller.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_LEAD      = 3'd2,
        ST_TRAIL     = 3'd3,
        ST_HOLD_WAIT = 3'd4,
        ST_CS_HOLD   = 3'd5
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Width of the chip-select index; never narrower than one bit.
    function automatic int cs_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_timer.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_timer
// Description : Half-SCLK-period counter with clear and terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_timer #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tc
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == CW'(HALF - 1));

endmodule
`default_nettype wire

// File: rtl/spi_controller_multi.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller_multi
// Description : SPI master with runtime CPOL/CPHA, NUM_CS selects, CS hold.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_controller_multi
    import spi_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CS         = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic [cs_width(NUM_CS)-1:0] cs_sel,
    input  logic [DATA_WIDTH-1:0]       data_to_send,
    input  logic                        hold_cs,
    input  logic                        SPI_MISO,
    output logic [DATA_WIDTH-1:0]       data_received,
    output logic                        busy,
    output logic                        done,
    output logic                        SPI_SCLK,
    output logic                        SPI_MOSI,
    output logic [NUM_CS-1:0]           SPI_CS
);

    localparam int HALF = CLK_FREQUENCY / SCLK_FREQUENCY / 2;
    localparam int CSW  = cs_width(NUM_CS);
    localparam int BW   = $clog2(DATA_WIDTH);

    if (HALF < 2) begin : g_half_check
        $error("spi_controller_multi: CLK_FREQUENCY/SCLK_FREQUENCY/2 must be >= 2");
    end
    if (DATA_WIDTH < 2) begin : g_width_check
        $error("spi_controller_multi: DATA_WIDTH must be >= 2");
    end

    state_t                r_state;
    state_t                w_next;
    spi_mode_t             r_mode;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_rx_out;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_done_pending;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sclk;
    logic                  r_mosi;
    logic [NUM_CS-1:0]     r_cs_n;
    logic [NUM_CS-1:0]     w_cs_hit;
    logic                  w_tc;
    logic                  w_enter;
    logic                  w_setup_cpha;

    // Out-of-range cs_sel decodes to no line, so the word runs with CS idle.
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
        assign w_cs_hit[gi] = (cs_sel == CSW'(gi));
    end

    spi_sclk_timer #(
        .HALF (HALF)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_enter),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:      if (start) w_next = ST_SETUP;
            ST_SETUP:     if (w_tc) w_next = ST_LEAD;
            ST_LEAD:      if (w_tc) w_next = ST_TRAIL;
            ST_TRAIL: begin
                if (w_tc) begin
                    if (r_bit_cnt != '0) w_next = ST_LEAD;
                    else if (hold_cs)    w_next = ST_HOLD_WAIT;
                    else                 w_next = ST_CS_HOLD;
                end
            end
            ST_HOLD_WAIT: begin
                if (start)         w_next = ST_SETUP;
                else if (!hold_cs) w_next = ST_CS_HOLD;
            end
            ST_CS_HOLD:   if (w_tc) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    assign w_enter      = (w_next != r_state);
    assign w_setup_cpha = (r_state == ST_IDLE) ? cpha : r_mode.cpha;

    // All outputs change only on the edge that enters a new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode         <= '0;
            r_tx           <= '0;
            r_rx           <= '0;
            r_rx_out       <= '0;
            r_bit_cnt      <= '0;
            r_done_pending <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_sclk         <= 1'b0;
            r_mosi         <= 1'b0;
            r_cs_n         <= '1;
        end else begin
            r_done <= 1'b0;
            if (w_enter) begin
                unique case (w_next)
                    ST_SETUP: begin
                        r_busy    <= 1'b1;
                        r_tx      <= data_to_send;
                        r_bit_cnt <= BW'(DATA_WIDTH - 1);
                        if (r_state == ST_IDLE) begin
                            r_mode <= '{cpol: cpol, cpha: cpha};
                            r_sclk <= cpol;
                            r_cs_n <= ~w_cs_hit;
                        end
                        if (!w_setup_cpha) r_mosi <= data_to_send[DATA_WIDTH-1];
                    end
                    ST_LEAD: begin
                        r_sclk <= ~r_mode.cpol;
                        if (r_state == ST_TRAIL) r_bit_cnt <= r_bit_cnt - BW'(1);
                        if (r_mode.cpha) begin
                            r_mosi <= r_tx[DATA_WIDTH-1];
                            r_tx   <= r_tx << 1;
                        end else begin
                            r_rx <= {r_rx[DATA_WIDTH-2:0], SPI_MISO};
                        end
                    end
                    ST_TRAIL: begin
                        r_sclk <= r_mode.cpol;
                        if (r_mode.cpha) begin
                            r_rx <= {r_rx[DATA_WIDTH-2:0], SPI_MISO};
                        end else if (r_bit_cnt != '0) begin
                            r_mosi <= r_tx[DATA_WIDTH-2];
                            r_tx   <= r_tx << 1;
                        end
                    end
                    ST_HOLD_WAIT: begin
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_rx_out <= r_rx;
                    end
                    ST_CS_HOLD: begin
                        r_done_pending <= (r_state == ST_TRAIL);
                    end
                    ST_IDLE: begin
                        r_busy         <= 1'b0;
                        r_cs_n         <= '1;
                        r_done_pending <= 1'b0;
                        if (r_done_pending) begin
                            r_done   <= 1'b1;
                            r_rx_out <= r_rx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_received = r_rx_out;
    assign busy          = r_busy;
    assign done          = r_done;
    assign SPI_SCLK      = r_sclk;
    assign SPI_MOSI      = r_mosi;
    assign SPI_CS        = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_controller_multi
// Description : Scoreboard bench for spi_controller_multi (HALF=4, 16-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_controller_multi;

    localparam int DW     = 16;
    localparam int HALF   = 4;
    localparam int T_DONE = HALF * (2 + 2 * DW);
    localparam int T_HOLD = HALF * (1 + 2 * DW);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          hold_cs = 1'b0;
    logic          loop_en = 1'b1;
    logic [1:0]    cs_sel = 2'd0;
    logic [DW-1:0] data_to_send = '0;
    logic [DW-1:0] miso_pat = '0;
    logic [DW-1:0] data_received, d3_rx, mosi_cap;
    logic          busy, done, sclk, mosi, spi_miso, miso_model;
    logic          d3_busy, d3_done, d3_sclk, d3_mosi;
    logic [3:0]    cs;
    logic [2:0]    d3_cs;
    int            cyc = 0, checks = 0, failures = 0;
    int            lead_cnt = 0, lead_base = 0, lead_n;
    logic [DW-1:0] exp_q[$];

    spi_controller_multi #(
        .CLK_FREQUENCY (100_000_000), .SCLK_FREQUENCY (12_500_000),
        .DATA_WIDTH (DW), .NUM_CS (4)
    ) u_dut (
        .clk (clk), .rst (rst), .start (start), .cpol (cpol), .cpha (cpha),
        .cs_sel (cs_sel), .data_to_send (data_to_send), .hold_cs (hold_cs),
        .SPI_MISO (spi_miso), .data_received (data_received), .busy (busy),
        .done (done), .SPI_SCLK (sclk), .SPI_MOSI (mosi), .SPI_CS (cs)
    );

    // A 2-bit cs_sel cannot exceed 3, so the out-of-range select is reached with NUM_CS=3.
    spi_controller_multi #(
        .CLK_FREQUENCY (100_000_000), .SCLK_FREQUENCY (12_500_000),
        .DATA_WIDTH (DW), .NUM_CS (3)
    ) u_dut3 (
        .clk (clk), .rst (rst), .start (start), .cpol (cpol), .cpha (cpha),
        .cs_sel (cs_sel), .data_to_send (data_to_send), .hold_cs (hold_cs),
        .SPI_MISO (spi_miso), .data_received (d3_rx), .busy (d3_busy),
        .done (d3_done), .SPI_SCLK (d3_sclk), .SPI_MOSI (d3_mosi), .SPI_CS (d3_cs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge sclk) mosi_cap <= {mosi_cap[DW-2:0], mosi};
    always @(negedge sclk) lead_cnt <= lead_cnt + 1;

    // Mode-3 peripheral model: presents bit (DW-n) after its n-th falling SCLK edge.
    assign lead_n     = lead_cnt - lead_base;
    assign miso_model = (lead_n >= 1 && lead_n <= DW) ? miso_pat[DW - lead_n] : 1'b0;
    assign spi_miso   = loop_en ? mosi : miso_model;

    task automatic issue_start(input logic [DW-1:0] word, input logic cp, input logic ch,
                               input logic [1:0] sel, input logic hold, output int t0);
        @(negedge clk);
        data_to_send = word; cpol = cp; cpha = ch; cs_sel = sel; hold_cs = hold;
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat, output bit ok,
                             output logic [3:0] cs_lo, output logic [3:0] cs_hi,
                             output logic [2:0] d3_lo, output int d3_rises);
        logic prev;
        ok = 1'b0; lat = -1; cs_lo = '0; cs_hi = '0; d3_lo = '0; d3_rises = 0;
        prev = d3_sclk;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cs_lo |= ~cs; cs_hi |= cs; d3_lo |= ~d3_cs;
            if (d3_sclk && !prev) d3_rises++;
            prev = d3_sclk;
            if (done) begin
                ok = 1'b1; lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (cs !== 4'hF)   begin failures++; $display("FAIL reset_cs: got %h expected f", cs); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (data_received !== '0) begin failures++; $display("FAIL reset_rx: got %h expected 0", data_received); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0();
        int t0, lat, rises; bit ok; logic [3:0] lo, hi; logic [2:0] dlo; logic [DW-1:0] exp;
        loop_en = 1'b1;
        issue_start(16'hA5C3, 1'b0, 1'b0, 2'd0, 1'b0, t0);
        exp_q.push_back(16'hA5C3);
        checks++; if (busy !== 1'b1)  begin failures++; $display("FAIL m0_busy: got %b expected 1", busy); end
        checks++; if (cs !== 4'b1110) begin failures++; $display("FAIL m0_cs: got %b expected 1110", cs); end
        wait_done(t0, lat, ok, lo, hi, dlo, rises);
        checks++; if (lat !== T_DONE) begin failures++; $display("FAIL m0_latency: got %0d expected %0d", lat, T_DONE); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (data_received !== exp) begin failures++; $display("FAIL m0_rx: got %h expected %h", data_received, exp); end
        checks++; if (mosi_cap !== 16'hA5C3) begin failures++; $display("FAIL m0_mosi: got %h expected a5c3", mosi_cap); end
        checks++; if (cs !== 4'hF || busy !== 1'b0) begin failures++; $display("FAIL m0_end: got cs=%h busy=%b expected cs=f busy=0", cs, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || sclk !== 1'b0) begin failures++; $display("FAIL m0_idle: got done=%b sclk=%b expected 0 0", done, sclk); end
    endtask

    task automatic test_mode3();
        int t0, lat, rises; bit ok; logic [3:0] lo, hi; logic [2:0] dlo; logic [DW-1:0] exp;
        loop_en = 1'b0;
        miso_pat = 16'h1234;
        lead_base = lead_cnt;
        issue_start(16'h8001, 1'b1, 1'b1, 2'd2, 1'b0, t0);
        exp_q.push_back(16'h1234);
        wait_done(t0, lat, ok, lo, hi, dlo, rises);
        checks++; if (lat !== T_DONE) begin failures++; $display("FAIL m3_latency: got %0d expected %0d", lat, T_DONE); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (data_received !== exp) begin failures++; $display("FAIL m3_rx: got %h expected %h", data_received, exp); end
        checks++; if (lo !== 4'b0100) begin failures++; $display("FAIL m3_cs_lines: got %b expected 0100", lo); end
        repeat (3) @(negedge clk);
        checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL m3_sclk_idle: got %b expected 1", sclk); end
        loop_en = 1'b1;
    endtask

    task automatic test_hold();
        int t0, t1, lat, rises, ndone, extra; bit ok; logic [3:0] lo, hi; logic [2:0] dlo; logic [DW-1:0] exp;
        ndone = 0;
        for (int w = 1; w <= 3; w++) begin
            issue_start(DW'(w), 1'b0, 1'b0, 2'd0, 1'b1, t0);
            exp_q.push_back(DW'(w));
            checks++; if (cs[0] !== 1'b0) begin failures++; $display("FAIL hold_cs_start%0d: got %b expected 0", w, cs[0]); end
            if (w == 2) begin
                for (int i = 0; i < 20 && sclk !== 1'b1; i++) @(negedge clk);
                checks++; if (cyc - t0 !== HALF) begin failures++; $display("FAIL hold_lead_gap: got %0d expected %0d", cyc - t0, HALF); end
            end
            wait_done(t0, lat, ok, lo, hi, dlo, rises);
            if (ok) ndone++;
            checks++; if (lat !== T_HOLD) begin failures++; $display("FAIL hold_latency%0d: got %0d expected %0d", w, lat, T_HOLD); end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if (data_received !== exp) begin failures++; $display("FAIL hold_rx%0d: got %h expected %h", w, data_received, exp); end
            checks++; if (hi[0] !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL hold_state%0d: got cs0_high=%b busy=%b expected 0 0", w, hi[0], busy); end
        end
        checks++; if (ndone !== 3) begin failures++; $display("FAIL hold_done_count: got %0d expected 3", ndone); end
        @(negedge clk);
        hold_cs = 1'b0;
        t1 = cyc + 1;
        extra = 0;
        for (int i = 0; i < 20 && cs[0] !== 1'b1; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++; if (cyc - t1 !== HALF) begin failures++; $display("FAIL hold_release: got %0d expected %0d", cyc - t1, HALF); end
        repeat (10) begin @(negedge clk); if (done) extra++; end
        checks++; if (extra !== 0) begin failures++; $display("FAIL hold_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_busy_start();
        int t0, lat, rises, extra; bit ok; logic [3:0] lo, hi; logic [2:0] dlo; logic [DW-1:0] exp;
        issue_start(16'h3C5A, 1'b0, 1'b0, 2'd0, 1'b0, t0);
        exp_q.push_back(16'h3C5A);
        repeat (5) @(negedge clk);
        data_to_send = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(t0, lat, ok, lo, hi, dlo, rises);
        checks++; if (lat !== T_DONE) begin failures++; $display("FAIL busy_latency: got %0d expected %0d", lat, T_DONE); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (data_received !== exp) begin failures++; $display("FAIL busy_rx: got %h expected %h", data_received, exp); end
        checks++; if (mosi_cap !== 16'h3C5A) begin failures++; $display("FAIL busy_mosi: got %h expected 3c5a", mosi_cap); end
        extra = 0;
        repeat (150) begin @(negedge clk); if (done) extra++; end
        checks++; if (extra !== 0 || busy !== 1'b0) begin failures++; $display("FAIL busy_extra: got dones=%0d busy=%b expected 0 0", extra, busy); end
    endtask

    task automatic test_cs_range();
        int t0, lat, rises; bit ok; logic [3:0] lo, hi; logic [2:0] dlo; logic [DW-1:0] exp;
        issue_start(16'h00FF, 1'b0, 1'b0, 2'd3, 1'b0, t0);
        exp_q.push_back(16'h00FF);
        wait_done(t0, lat, ok, lo, hi, dlo, rises);
        checks++; if (!ok) begin failures++; $display("FAIL csr_done: got timeout expected done"); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (data_received !== exp) begin failures++; $display("FAIL csr_rx: got %h expected %h", data_received, exp); end
        checks++; if (lo !== 4'b1000) begin failures++; $display("FAIL csr_cs4: got %b expected 1000", lo); end
        checks++; if (dlo !== 3'b000) begin failures++; $display("FAIL csr_cs3: got %b expected 000", dlo); end
        checks++; if (rises !== DW) begin failures++; $display("FAIL csr_sclk: got %0d expected %0d", rises, DW); end
        checks++; if (d3_done !== 1'b1 || d3_rx !== 16'h00FF) begin failures++; $display("FAIL csr_d3: got done=%b rx=%h expected 1 00ff", d3_done, d3_rx); end
    endtask

    task automatic test_mid_reset();
        int t0, lat, rises, extra; bit ok; logic [3:0] lo, hi; logic [2:0] dlo; logic [DW-1:0] exp;
        issue_start(16'hBEEF, 1'b0, 1'b0, 2'd1, 1'b0, t0);
        exp_q.push_back(16'hBEEF);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (cs !== 4'hF || sclk !== 1'b0 || mosi !== 1'b0) begin failures++; $display("FAIL rst_lines: got cs=%h sclk=%b mosi=%b expected f 0 0", cs, sclk, mosi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_flags: got busy=%b done=%b expected 0 0", busy, done); end
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (150) begin @(negedge clk); if (done) extra++; end
        checks++; if (extra !== 0 || data_received !== '0) begin failures++; $display("FAIL rst_no_done: got dones=%0d rx=%h expected 0 0", extra, data_received); end
        issue_start(16'h0F0F, 1'b0, 1'b0, 2'd0, 1'b0, t0);
        exp_q.push_back(16'h0F0F);
        wait_done(t0, lat, ok, lo, hi, dlo, rises);
        checks++; if (lat !== T_DONE) begin failures++; $display("FAIL rst_after_latency: got %0d expected %0d", lat, T_DONE); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (data_received !== exp) begin failures++; $display("FAIL rst_after_rx: got %h expected %h", data_received, exp); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_hold();
        test_busy_start();
        test_cs_range();
        test_mid_reset();
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
